// File: rtl/fifo_write_arbiter_if.sv
// Producer-side request bus and FIFO write port shared by fifo_write_arbiter.
// The arbiter connects through the master modport; the producers and the FIFO connect through the slave modport.
interface fifo_write_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic                        arb_en;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        fifo_full;
  logic                        fifo_w_en;
  logic [DATA_WIDTH-1:0]       fifo_data_in;
  logic [GW-1:0]               grant_id;
  logic                        busy;

  modport master (
    input  arb_en, req_valid, req_data, fifo_full,
    output req_ready, fifo_w_en, fifo_data_in, grant_id, busy
  );

  modport slave (
    output arb_en, req_valid, req_data, fifo_full,
    input  req_ready, fifo_w_en, fifo_data_in, grant_id, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter that shares one async_fifo write port among N_REQ producers.
// Latency: the grant is registered one cycle after a request; the write port is combinational from state, so beats pass with zero latency.
// Backpressure: fifo_full clears req_ready and fifo_w_en, and the burst stalls with beat_cnt held.
module fifo_write_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input logic                  w_clk,
  input logic                  w_rst_n,
  fifo_write_arbiter_if.master bus
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [GW-1:0] next_grant;
  logic          found;
  logic          xfer;
  logic          in_burst;
  int unsigned   cand;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // Scan starts just after the previous owner, so every requester is reached within N_REQ grants.
  always_comb begin
    next_grant = last_q;
    found      = 1'b0;
    cand       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_q) + k) % N_REQ;
      if (!found && bus.req_valid[cand]) begin
        next_grant = GW'(cand);
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    xfer    = bus.req_valid[grant_q] & ~bus.fifo_full;
    case (state_q)
      IDLE: begin
        if (bus.arb_en && found) begin
          state_d = BURST;
          grant_d = next_grant;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (xfer) beat_d = beat_q + CW'(1);
        // Burst limit, a producer going idle, or arb_en low all close the grant; a beat in this cycle still lands.
        if ((xfer && beat_d == CW'(MAX_BURST)) || !bus.req_valid[grant_q] || !bus.arb_en) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_burst         = (state_q == BURST);
  assign bus.busy         = in_burst;
  assign bus.grant_id     = grant_q;
  assign bus.fifo_w_en    = in_burst & bus.req_valid[grant_q] & ~bus.fifo_full;
  assign bus.fifo_data_in = in_burst ? bus.req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_comb begin
    bus.req_ready = '0;
    if (in_burst && !bus.fifo_full) bus.req_ready[grant_q] = 1'b1;
  end
endmodule
